// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the 4-way write-back L1 data cache.
// Also holds the byte-enable word merge used by hits and write-allocate fills.
package l1_cache_pkg;
  localparam int TAG_W  = 14;
  localparam int IDX_W  = 13;
  localparam int WAYS   = 4;
  localparam int LINE_W = 256;
  localparam int SETS   = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WBACK,
    FILLREQ,
    FILLWAIT,
    DONE
  } state_e;

  // ram_test field select (a[4:2]): codes 0..3 are the tag of that way.
  localparam logic [2:0] RT_TAG_LAST = 3'd3;
  localparam logic [2:0] RT_STATE    = 3'd4;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [2:0]        word,
                                                   input logic [31:0]       wd,
                                                   input logic [3:0]        be);
    logic [LINE_W-1:0] res;
    int off;
    res = line;
    for (int b = 0; b < 4; b++) begin
      off = 32 * int'(word) + 8 * b;
      if (be[b]) res[off +: 8] = wd[b*8 +: 8];
    end
    return res;
  endfunction
endpackage

// File: rtl/l1_cache_plru.sv
// Tree pseudo-LRU for one 4-way set: next state after touching a way, and
// the replacement victim (lowest invalid way first, otherwise the tree pick).
module l1_plru
  import l1_cache_pkg::*;
(
  input  logic [2:0]      lru,
  input  logic [1:0]      acc_way,
  input  logic [WAYS-1:0] valid,
  output logic [2:0]      lru_next,
  output logic [1:0]      victim
);
  // lru[0]=1 -> victim side is ways 2-3; lru[1] picks 1/0; lru[2] picks 3/2.
  always_comb begin
    lru_next = lru;
    case (acc_way)
      2'd0:    begin lru_next[0] = 1'b1; lru_next[1] = 1'b1; end
      2'd1:    begin lru_next[0] = 1'b1; lru_next[1] = 1'b0; end
      2'd2:    begin lru_next[0] = 1'b0; lru_next[2] = 1'b1; end
      default: begin lru_next[0] = 1'b0; lru_next[2] = 1'b0; end
    endcase
  end

  always_comb begin
    if (!valid[0])      victim = 2'd0;
    else if (!valid[1]) victim = 2'd1;
    else if (!valid[2]) victim = 2'd2;
    else if (!valid[3]) victim = 2'd3;
    else if (lru[0])    victim = lru[2] ? 2'd3 : 2'd2;
    else                victim = lru[1] ? 2'd1 : 2'd0;
  end
endmodule

// File: rtl/l1_cache.sv
// 4-way set-associative write-back/write-allocate L1 data cache, one request at a time.
// Handshake: read/write are one-cycle pulses accepted only in IDLE; every accepted request ends with one rd_valid pulse.
module l1_cache
  import l1_cache_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       a,
  input  logic [3:0]        be,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       wd,
  input  logic              ram_test,
  output logic [31:0]       rd,
  output logic              rd_valid,
  output logic              req_hit,
  output logic [31:0]       mm_a,
  output logic [LINE_W-1:0] mm_wd,
  output logic              mm_write,
  output logic              mm_read,
  input  logic [LINE_W-1:0] mm_rd,
  input  logic              mm_valid
);
  logic [TAG_W-1:0]          tag_ram  [WAYS][SETS];
  logic [LINE_W-1:0]         data_ram [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0] valid_bits;
  logic [SETS-1:0][WAYS-1:0] mod_bits;
  logic [SETS-1:0][2:0]      lru_bits;

  state_e      state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        rt_q, rt_d;
  logic [1:0]  way_q, way_d;

  logic [TAG_W-1:0]  in_tag, tag_q;
  logic [IDX_W-1:0]  in_idx, idx_q;
  logic [2:0]        word_q;
  logic              in_hit, victim_dirty, fill_en, acc_en, rt_wr;
  logic [1:0]        in_hit_way, victim;
  logic [2:0]        plru_cur, lru_next;
  logic [LINE_W-1:0] cur_line;
  logic [31:0]       rt_field;
  logic              unused_byte;

  assign in_tag      = a[31:18];
  assign in_idx      = a[17:5];
  assign tag_q       = addr_q[31:18];
  assign idx_q       = addr_q[17:5];
  assign word_q      = addr_q[4:2];
  assign unused_byte = ^a[1:0];
  assign cur_line    = data_ram[way_q][idx_q];

  // Victim lookup uses the incoming set in IDLE; updates use the latched set.
  assign plru_cur = (state_q == IDLE) ? lru_bits[in_idx] : lru_bits[idx_q];

  l1_plru u_plru (
    .lru      (plru_cur),
    .acc_way  (way_q),
    .valid    (valid_bits[in_idx]),
    .lru_next (lru_next),
    .victim   (victim)
  );

  always_comb begin
    in_hit     = 1'b0;
    in_hit_way = 2'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_bits[in_idx][w] && tag_ram[w][in_idx] == in_tag) begin
        in_hit     = 1'b1;
        in_hit_way = 2'(w);
      end
    end
    victim_dirty = valid_bits[in_idx][victim] & mod_bits[in_idx][victim];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rt_q    <= 1'b0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rt_q    <= rt_d;
      way_q   <= way_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    wr_d    = wr_q;
    rt_d    = rt_q;
    way_d   = way_q;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          addr_d = a[31:2];
          wd_d   = wd;
          be_d   = be;
          wr_d   = write;
          rt_d   = ram_test;
          if (ram_test) begin
            state_d = DONE;
          end else if (in_hit) begin
            way_d   = in_hit_way;
            state_d = LOOKUP;
          end else begin
            way_d   = victim;
            state_d = victim_dirty ? WBACK : FILLREQ;
          end
        end
      end
      LOOKUP:   state_d = IDLE;
      WBACK:    state_d = FILLREQ;
      FILLREQ:  state_d = FILLWAIT;
      FILLWAIT: if (mm_valid) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rt_field = '0;
    if (word_q == RT_STATE)
      rt_field = {21'b0, valid_bits[idx_q], mod_bits[idx_q], lru_bits[idx_q]};
    else if (word_q <= RT_TAG_LAST)
      rt_field = {{(32-TAG_W){1'b0}}, tag_ram[word_q[1:0]][idx_q]};
  end

  // LOOKUP completes a hit; DONE completes a filled miss or a ram_test access.
  always_comb begin
    rd       = '0;
    rd_valid = 1'b0;
    req_hit  = 1'b0;
    mm_a     = '0;
    mm_wd    = '0;
    mm_write = 1'b0;
    mm_read  = 1'b0;
    case (state_q)
      LOOKUP, DONE: begin
        rd_valid = 1'b1;
        req_hit  = (state_q == LOOKUP);
        rd       = rt_q ? rt_field : cur_line[{word_q, 5'b0} +: 32];
      end
      WBACK: begin
        mm_write = 1'b1;
        mm_a     = {tag_ram[way_q][idx_q], idx_q, 5'b0};
        mm_wd    = cur_line;
      end
      FILLREQ: begin
        mm_read = 1'b1;
        mm_a    = {addr_q[31:5], 5'b0};
      end
      FILLWAIT: mm_a = {addr_q[31:5], 5'b0};
      default: ;
    endcase
  end

  always_comb begin
    fill_en = (state_q == FILLWAIT) && mm_valid && !reset;
    acc_en  = (state_q == LOOKUP || state_q == DONE) && !rt_q && !reset;
    rt_wr   = (state_q == DONE) && rt_q && wr_q && !reset;
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_ram[way_q][idx_q] <= mm_rd;
      tag_ram[way_q][idx_q]  <= tag_q;
    end else if (acc_en && wr_q) begin
      data_ram[way_q][idx_q] <= merge_word(cur_line, word_q, wd_q, be_q);
    end
    if (rt_wr && word_q <= RT_TAG_LAST) tag_ram[word_q[1:0]][idx_q] <= wd_q[TAG_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      mod_bits   <= '0;
      lru_bits   <= '0;
    end else begin
      if (fill_en) begin
        valid_bits[idx_q][way_q] <= 1'b1;
        mod_bits[idx_q][way_q]   <= 1'b0;
        lru_bits[idx_q]          <= lru_next;
      end
      if (acc_en) begin
        lru_bits[idx_q] <= lru_next;
        if (wr_q) mod_bits[idx_q][way_q] <= 1'b1;
      end
      if (rt_wr && word_q == RT_STATE) begin
        valid_bits[idx_q] <= wd_q[10:7];
        mod_bits[idx_q]   <= wd_q[6:3];
        lru_bits[idx_q]   <= wd_q[2:0];
      end
    end
  end
endmodule

// File: tb/tb_l1_cache.sv
// Directed plus randomized bench for l1_cache against a set/way reference model
// and a sparse main-memory model; every completion is checked for data, hit and timing.
module tb_l1_cache;
  logic         clk = 1'b0;
  logic         reset, read, write, ram_test, rd_valid, req_hit, mm_write, mm_read, mm_valid;
  logic [31:0]  a, wd, rd, mm_a;
  logic [3:0]   be;
  logic [255:0] mm_wd, mm_rd;
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  l1_cache dut (
    .clk(clk), .reset(reset), .a(a), .be(be), .read(read), .write(write), .wd(wd),
    .ram_test(ram_test), .rd(rd), .rd_valid(rd_valid), .req_hit(req_hit), .mm_a(mm_a),
    .mm_wd(mm_wd), .mm_write(mm_write), .mm_read(mm_read), .mm_rd(mm_rd), .mm_valid(mm_valid)
  );

  // Reference model: only sets 0..7 are exercised.
  logic [3:0]   m_v   [8];
  logic [3:0]   m_m   [8];
  logic [2:0]   m_lru [8];
  logic [13:0]  m_tag [8][4];
  logic [255:0] m_data[8][4];
  logic [255:0] mem [logic [31:0]];

  localparam logic [3:0] V_TAB [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
  localparam logic [2:0] L_TAB [5] = '{3'b011, 3'b001, 3'b100, 3'b000, 3'b011};

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem.exists(la)) return mem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = la ^ (32'h9E37_0000 + 32'(w));
    return l;
  endfunction

  function automatic logic [255:0] merge(input logic [255:0] line, input int word,
                                         input logic [31:0] d, input logic [3:0] bev);
    logic [255:0] r;
    r = line;
    for (int b = 0; b < 4; b++) if (bev[b]) r[word*32 + b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Accessing a way makes both tree levels on its path point at the other side.
  function automatic logic [2:0] lru_touch(input logic [2:0] l, input int w);
    logic [2:0] r;
    r = l;
    if (w < 2) begin r[0] = 1'b1; r[1] = (w == 0); end
    else       begin r[0] = 1'b0; r[2] = (w == 2); end
    return r;
  endfunction

  function automatic int pick_victim(input logic [3:0] v, input logic [2:0] l);
    for (int w = 0; w < 4; w++) if (!v[w]) return w;
    return l[0] ? 2 + int'(l[2]) : int'(l[1]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_v[i] = '0; m_m[i] = '0; m_lru[i] = '0; end
  endtask

  task automatic access(input bit rt, input bit wr, input bit both, input logic [31:0] addr,
                        input logic [3:0] bev, input logic [31:0] wdv, input bit spurious,
                        output logic [31:0] rd_out);
    int idx, word, way, fill_at, cyc, n_wr, n_rq;
    logic [13:0]  tag;
    bit           hit, dirty, done;
    logic [31:0]  wb_a, fill_a, exp_rd;
    logic [255:0] wb_d, fill_d;
    idx = int'(addr[17:5]); tag = addr[31:18]; word = int'(addr[4:2]);
    hit = 0; dirty = 0; way = 0; wb_a = '0; wb_d = '0; fill_a = '0; fill_d = '0;
    rd_out = '0;
    if (!rt) begin
      for (int w = 0; w < 4; w++)
        if (m_v[idx][w] && m_tag[idx][w] == tag) begin hit = 1; way = w; end
      if (!hit) begin
        way    = pick_victim(m_v[idx], m_lru[idx]);
        dirty  = m_v[idx][way] && m_m[idx][way];
        wb_a   = {m_tag[idx][way], addr[17:5], 5'b0};
        wb_d   = m_data[idx][way];
        fill_a = {addr[31:5], 5'b0};
        fill_d = mem_line(fill_a);
      end
      exp_rd = hit ? m_data[idx][way][word*32 +: 32] : fill_d[word*32 +: 32];
    end else if (word < 4) exp_rd = {18'b0, m_tag[idx][word]};
    else if (word == 4)    exp_rd = {21'b0, m_v[idx], m_m[idx], m_lru[idx]};
    else                   exp_rd = '0;

    @(posedge clk); #1;
    check32("idle_quiet", {29'b0, rd_valid, mm_read, mm_write}, 32'd0);
    a = addr; be = bev; wd = wdv; ram_test = rt; write = wr; read = !wr || both;
    @(posedge clk); #1;
    read = 0; write = 0; ram_test = 0;
    if (spurious && !rt && !hit) begin read = 1; a = addr ^ 32'h0004_0000; end
    cyc = 1; done = 0; fill_at = -1; n_wr = 0; n_rq = 0;
    while (!done && cyc < 60) begin
      if (mm_write) begin
        n_wr++;
        check_i("wb_cycle", cyc, 1);
        check32("wb_addr", mm_a, wb_a);
        check_line("wb_data", mm_wd, wb_d);
      end
      if (mm_read) begin
        n_rq++;
        check_i("fill_cycle", cyc, dirty ? 2 : 1);
        check32("fill_addr", mm_a, fill_a);
        fill_at = cyc + 1 + int'($urandom_range(0, 3));
      end
      if (rd_valid) begin
        done = 1;
        check_i("done_cycle", cyc, (rt || hit) ? 1 : fill_at + 1);
        check32("req_hit", 32'(req_hit), 32'(hit));
        if (!wr) check32("rd", rd, exp_rd);
        rd_out = rd;
      end else begin
        mm_valid = (cyc == fill_at);
        mm_rd    = (cyc == fill_at) ? fill_d : '0;
        @(posedge clk); #1;
        cyc++;
        read = 0;
      end
    end
    mm_valid = 0; mm_rd = '0;
    if (!done) check_i("timeout", 0, 1);
    check_i("wb_count", n_wr, int'(!rt && !hit && dirty));
    check_i("fill_count", n_rq, int'(!rt && !hit));

    if (rt) begin
      if (wr) begin
        if (word < 4) m_tag[idx][word] = wdv[13:0];
        else if (word == 4) {m_v[idx], m_m[idx], m_lru[idx]} = wdv[10:0];
      end
    end else begin
      if (!hit) begin
        if (dirty) mem[wb_a] = wb_d;
        m_tag[idx][way] = tag; m_data[idx][way] = fill_d;
        m_v[idx][way] = 1'b1; m_m[idx][way] = 1'b0;
      end
      if (wr) begin
        m_data[idx][way] = merge(m_data[idx][way], word, wdv, bev);
        m_m[idx][way] = 1'b1;
      end
      m_lru[idx] = lru_touch(m_lru[idx], way);
    end
  endtask

  function automatic logic [31:0] st_addr(input int set);
    return {14'd0, 13'(set), 3'd4, 2'b0};
  endfunction

  initial begin
    logic [31:0]  r;
    logic [255:0] l;
    reset = 1; read = 0; write = 0; ram_test = 0; a = '0; be = '0; wd = '0;
    mm_valid = 0; mm_rd = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check32("rst_rd", rd, 0);
    check32("rst_rd_valid", 32'(rd_valid), 0);
    check32("rst_req_hit", 32'(req_hit), 0);
    check32("rst_mm_read", 32'(mm_read), 0);
    check32("rst_mm_write", 32'(mm_write), 0);
    check32("rst_mm_a", mm_a, 0);
    check_line("rst_mm_wd", mm_wd, '0);
    reset = 0;

    // Cold read miss then hit on line 0.
    l = mem_line(32'h0);
    l[31:0] = 32'h1111_1111; l[63:32] = 32'h1234_5678;
    mem[32'h0] = l;
    access(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, r);
    check32("cold_rd", r, 32'h1111_1111);
    access(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, r);

    // Partial write hit, read back and mod bit.
    access(0, 1, 0, 32'h4, 4'b0011, 32'hAABB_CCDD, 0, r);
    access(0, 0, 0, 32'h4, 4'h0, 32'h0, 0, r);
    check32("merge_rd", r, 32'h1234_CCDD);
    access(1, 0, 0, st_addr(0), 4'h0, 32'h0, 0, r);
    check32("mod_state", r, {21'b0, 4'b0001, 4'b0001, 3'b011});

    // Fill order and pLRU evolution in set 3.
    for (int t = 0; t < 5; t++) begin
      access(0, 0, 0, {14'(t), 13'd3, 5'd0}, 4'h0, 32'h0, 0, r);
      access(1, 0, 0, st_addr(3), 4'h0, 32'h0, 0, r);
      check32("plru_state", r, {21'b0, V_TAB[t], 4'b0000, L_TAB[t]});
    end
    access(1, 0, 0, {14'd0, 13'd3, 3'd0, 2'b0}, 4'h0, 32'h0, 0, r);
    check32("evict_way0_tag", r, 32'd4);

    // Dirty eviction in set 5.
    for (int t = 0; t < 4; t++)
      access(0, 1, 0, {14'(t), 13'd5, 5'd8}, 4'hF, $urandom, 0, r);
    access(0, 0, 0, {14'd4, 13'd5, 5'd0}, 4'h0, 32'h0, 0, r);

    // ram_test tag write and read-back.
    access(1, 1, 0, {14'd0, 13'd7, 3'd2, 2'b0}, 4'hF, 32'h0000_02A5, 0, r);
    access(1, 0, 0, {14'd0, 13'd7, 3'd2, 2'b0}, 4'h0, 32'h0, 0, r);
    check32("rt_tag_rd", r, 32'h0000_02A5);

    // Reset while waiting for fill data.
    @(posedge clk); #1;
    a = {14'd9, 13'd6, 5'd0}; read = 1;
    @(posedge clk); #1;
    read = 0;
    check32("abort_mm_read", 32'(mm_read), 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; mm_valid = 1; mm_rd = {8{32'hDEAD_BEEF}};
    check32("abort_rd_valid", 32'(rd_valid), 0);
    check32("abort_mm_a", mm_a, 0);
    check32("abort_mm_read2", 32'(mm_read), 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mm_valid = 0; mm_rd = '0;
      check32("abort_quiet", {29'b0, rd_valid, mm_read, mm_write}, 0);
    end
    access(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, r);
    check32("post_reset_miss", r, 32'h1111_1111);

    // Randomized traffic over a small footprint to force conflicts.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        access(1, 0, 0, st_addr(int'($urandom_range(0, 7))), 4'h0, 32'h0, 0, r);
      end else begin
        bit wr;
        wr = 1'($urandom_range(0, 1));
        access(0, wr, wr && ($urandom_range(0, 3) == 0),
               {14'($urandom_range(0, 5)), 13'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b0},
               4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/l1_cache.md
# l1_cache

Write-back, write-allocate, 4-way set-associative 1 MB L1 data cache with 32-byte lines and tree pseudo-LRU replacement. It sits between a 32-bit word-oriented requester and a 256-bit line-oriented main memory, handling one request at a time. A ram_test mode gives the requester direct read/write access to the tag and state arrays.

## Interface
- Parameters: none. Fixed geometry: 8192 sets, 4 ways, 256-bit lines, 14-bit tags.
- Address split: tag = a[31:18], index = a[17:5], word = a[4:2], byte = a[1:0] (byte field ignored).
- clk  in  1  single clock; everything is posedge.
- reset  in  1  synchronous, active-high.
- a  in  32  request byte address.
- be  in  4  byte enables for writes; ignored on reads.
- read  in  1  read request, one-cycle pulse.
- write  in  1  write request, one-cycle pulse.
- wd  in  32  write data.
- ram_test  in  1  direct tag/state array access mode.
- rd  out  32  read data.
- rd_valid  out  1  one-cycle completion pulse for every request.
- req_hit  out  1  one-cycle pulse, concurrent with rd_valid, when the request hit.
- mm_a  out  32  line-aligned memory address; bits [4:0] are 0.
- mm_wd  out  256  writeback line data.
- mm_write  out  1  writeback pulse, one cycle.
- mm_read  out  1  fill request pulse, one cycle.
- mm_rd  in  256  fill data.
- mm_valid  in  1  fill data valid, one cycle, any latency.

## Operation
- Per-set state: valid[3:0], mod[3:0], lru[2:0]. Held in flop arrays; all cleared by reset. Tag and data arrays are not reset.
- Lookup: a way hits when valid is set and its tag equals a[31:18].
- Read and write asserted together: treated as a write.
- Read hit: rd = data word a[4:2] of the hit way.
- Write hit: merge wd into the word under be; set mod.
- Miss, victim selection: lowest-numbered invalid way, otherwise the pLRU victim.
- Miss, dirty victim: writeback first. mm_a = {victim tag, index, 5'b0}, mm_wd = victim line.
- Miss, fill: mm_read with mm_a = {a[31:5], 5'b0}. On mm_valid, install mm_rd and the new tag, set valid, clear mod. If the request is a write, merge wd (with mod set).
- Miss completion: identical to a hit access, except req_hit = 0.
- pLRU update on every access or fill: lru[0] = 1 means the victim is in ways 2-3; lru[1] picks way1(1)/way0(0); lru[2] picks way3(1)/way2(0). On access to way w, set the bits to point away from w.
- ram_test = 1: no memory traffic.
  - a[4:2] = 0..3 selects the tag of way n (wd[13:0]).
  - a[4:2] = 4 selects the state bits {valid[3:0], mod[3:0], lru[2:0]} (wd[10:0]).
  - The set is a[17:5]. Reads return the field zero-extended. Both reads and writes complete with rd_valid, req_hit = 0.
- Requests arriving while not IDLE are ignored.

## Timing
- Reset values: rd = 0, rd_valid = 0, req_hit = 0, mm_read = 0, mm_write = 0, mm_a = 0, mm_wd = 0; state = IDLE.
- States: IDLE, LOOKUP, WBACK, FILLREQ, FILLWAIT, DONE.
- Request sampled in IDLE at cycle N.
- Hit: rd_valid/req_hit at N+1.
- Clean miss: mm_read at N+1. Dirty miss: mm_write at N+1, mm_read at N+2.
- Fill: data is written the cycle mm_valid is seen; rd_valid asserts the following cycle; return to IDLE.
- Reset during any state forces IDLE and aborts the request; no partial pulses follow.

## Structure
- Shared package holds: state enum; TAG_W = 14, IDX_W = 13, WAYS = 4, LINE_W = 256; ram_test field codes.
- One sub-module, l1_plru: lru + hit way -> next lru; lru + valid -> victim way.
- Arrays are named tag_ram, data_ram, valid_bits, mod_bits, lru_bits so bench probes can read them hierarchically.

## Test plan
- After reset, read 0x0000_0000 -> mm_read with mm_a = 0; return mm_rd word0 = 0x1111_1111 -> rd = 0x1111_1111, req_hit = 0; repeat read -> rd_valid at N+1 with req_hit = 1.
- Write 0x0000_0004, be = 4'b0011, wd = 0xAABB_CCDD, onto a filled line whose word1 = 0x1234_5678 -> read back 0x1234_CCDD; mod[way] = 1.
- Five reads with the same index, tags 0..4 -> ways 0, 1, 2, 3 filled in order; the fifth access evicts way 0; lru state matches the pLRU rules after each access.
- Dirty eviction: dirty line in the victim way -> mm_write with old tag address and modified data one cycle before mm_read.
- ram_test: write tag 0x2A5 to way 2 of set 7, then read it back -> rd = 0x0000_02A5; no mm traffic.
- Reset asserted mid-FILLWAIT -> outputs zero, IDLE; a subsequent read misses.
